// File: rtl/circuito_sweep_driver.sv
// Exhaustive sweep driver for the 9-input circuito block: drives all 512 vectors and counts ones
// on X, Y and X&Y. Define SWEEP_SIGNATURE_EN to add a 16-bit MISR over the sampled outputs.
module circuito_sweep_driver #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_x_in,
  input  logic        i_y_in,
  output logic [8:0]  o_vec,
  output logic        o_busy,
  output logic        o_done,
  output logic [9:0]  o_x_count,
  output logic [9:0]  o_y_count,
`ifdef SWEEP_SIGNATURE_EN
  output logic [9:0]  o_xy_count,
  output logic [15:0] o_signature
`else
  output logic [9:0]  o_xy_count
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  logic [1:0] r_state;
  logic [3:0] r_settle;
  logic [8:0] r_vec;
  logic       r_busy;
  logic       r_done;
  logic [9:0] r_x_count;
  logic [9:0] r_y_count;
  logic [9:0] r_xy_count;

`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] r_sig;
  logic        w_fb;
  logic [15:0] w_sig_next;

  // Right-shifting MISR: X folds in at the feedback tap, Y is injected at the MSB.
  always_comb begin
    w_fb       = r_sig[0] ^ i_x_in;
    w_sig_next = (r_sig >> 1) ^ (w_fb ? 16'hB400 : 16'h0000) ^ {i_y_in, 15'b0};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig <= 16'h0000;
    end else if ((r_state == ST_IDLE || r_state == ST_DONE) && i_start && !i_abort) begin
      r_sig <= 16'hFFFF;
    end else if (r_state == ST_SAMPLE && !i_abort) begin
      r_sig <= w_sig_next;
    end
  end

  assign o_signature = r_sig;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_settle   <= 4'd0;
      r_vec      <= 9'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_x_count  <= 10'd0;
      r_y_count  <= 10'd0;
      r_xy_count <= 10'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start && !i_abort) begin
            r_state    <= ST_WAIT;
            r_settle   <= SETTLE_LD;
            r_vec      <= 9'd0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_x_count  <= 10'd0;
            r_y_count  <= 10'd0;
            r_xy_count <= 10'd0;
          end
        end
        ST_WAIT: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_vec   <= 9'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (r_settle == 4'd0) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        default: begin // ST_SAMPLE
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_vec   <= 9'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_x_count  <= r_x_count + {9'd0, i_x_in};
            r_y_count  <= r_y_count + {9'd0, i_y_in};
            r_xy_count <= r_xy_count + {9'd0, i_x_in & i_y_in};
            if (r_vec == 9'd511) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ST_WAIT;
              r_vec    <= r_vec + 9'd1;
              r_settle <= SETTLE_LD;
            end
          end
        end
      endcase
    end
  end

  assign o_vec      = r_vec;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_x_count  = r_x_count;
  assign o_y_count  = r_y_count;
  assign o_xy_count = r_xy_count;

endmodule

// File: tb/tb_circuito_sweep_driver.sv
// Bench for circuito_sweep_driver: two instances (SETTLE=2 and SETTLE=1) share control inputs;
// X/Y responses come from per-vector lookup tables that also feed the reference model.
module tb_circuito_sweep_driver;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [8:0] vec1, vec2;
  logic       busy1, busy2, done1, done2;
  logic [9:0] xc1, yc1, xyc1, xc2, yc2, xyc2;
  logic       x_tab [512];
  logic       y_tab [512];
  logic       x1, y1, x2, y2;
`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] sig1, sig2;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  assign x1 = x_tab[vec1];
  assign y1 = y_tab[vec1];
  assign x2 = x_tab[vec2];
  assign y2 = y_tab[vec2];

  circuito_sweep_driver #(.SETTLE(2)) dut2 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_abort    (abort),
    .i_x_in     (x2),
    .i_y_in     (y2),
    .o_vec      (vec2),
    .o_busy     (busy2),
    .o_done     (done2),
    .o_x_count  (xc2),
    .o_y_count  (yc2),
`ifdef SWEEP_SIGNATURE_EN
    .o_xy_count (xyc2),
    .o_signature(sig2)
`else
    .o_xy_count (xyc2)
`endif
  );

  circuito_sweep_driver #(.SETTLE(1)) dut1 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_abort    (abort),
    .i_x_in     (x1),
    .i_y_in     (y1),
    .o_vec      (vec1),
    .o_busy     (busy1),
    .o_done     (done1),
    .o_x_count  (xc1),
    .o_y_count  (yc1),
`ifdef SWEEP_SIGNATURE_EN
    .o_xy_count (xyc1),
    .o_signature(sig1)
`else
    .o_xy_count (xyc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the number of edges after the start edge at which done was first seen, or -1.
  task automatic wait_done(input int which, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (((which == 1) ? done1 : done2) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic fill_tables(input int mode);
    for (int v = 0; v < 512; v++) begin
      logic [8:0] b;
      b = 9'(v);
      case (mode)
        0: begin x_tab[v] = b[8] & b[7]; y_tab[v] = ^b; end
        1: begin x_tab[v] = 1'b1;        y_tab[v] = 1'b1; end
        default: begin x_tab[v] = 1'($urandom); y_tab[v] = 1'($urandom); end
      endcase
    end
  endtask

  // Counts of ones over vectors [0, n) of the current tables.
  task automatic model_counts(input int n, output int xc, output int yc, output int xyc);
    xc = 0; yc = 0; xyc = 0;
    for (int v = 0; v < n; v++) begin
      xc  += int'(x_tab[v]);
      yc  += int'(y_tab[v]);
      xyc += int'(x_tab[v] & y_tab[v]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    fill_tables(2);
    #3;
    tests_run++;
    if ({vec1, vec2, busy1, busy2, done1, done2} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: vec1=%0d vec2=%0d busy=%b%b done=%b%b required all 0",
               vec1, vec2, busy1, busy2, done1, done2);
    end
    tests_run++;
    if ({xc1, yc1, xyc1, xc2, yc2, xyc2} !== 60'd0) begin
      tests_failed++;
      $display("FAIL reset_counts: %0d %0d %0d %0d %0d %0d required all 0",
               xc1, yc1, xyc1, xc2, yc2, xyc2);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    tests_run++;
    if ({vec1, vec2, busy1, busy2, done1, done2, xc1, yc2, xyc2} !== 52'd0) begin
      tests_failed++;
      $display("FAIL idle_hold: vec1=%0d vec2=%0d busy=%b%b done=%b%b required all 0",
               vec1, vec2, busy1, busy2, done1, done2);
    end
  endtask

  task automatic test_ab_parity();
    int n, exc, eyc, exyc;
    fill_tables(0);
    do_reset();
    pulse_start();
    tests_run++;
    if (busy2 !== 1'b1 || vec2 !== 9'd0) begin
      tests_failed++;
      $display("FAIL ab_start: busy=%b vec=%0d required busy=1 vec=0", busy2, vec2);
    end
    wait_done(2, 3000, n);
    model_counts(512, exc, eyc, exyc);
    tests_run++;
    if (n !== 1536) begin
      tests_failed++;
      $display("FAIL ab_done_time: edges=%0d required 1536", n);
    end
    tests_run++;
    if (int'(xc2) !== exc || int'(yc2) !== eyc || int'(xyc2) !== exyc) begin
      tests_failed++;
      $display("FAIL ab_counts: x=%0d y=%0d xy=%0d required %0d %0d %0d",
               xc2, yc2, xyc2, exc, eyc, exyc);
    end
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (vec2 !== 9'd511 || done2 !== 1'b1 || busy2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL ab_hold: vec=%0d done=%b busy=%b required 511 1 0", vec2, done2, busy2);
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    fill_tables(1);
    do_reset();
    pulse_start();
    for (int i = 1; i < 100; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy1 !== 1'b1 || vec1 !== 9'd50) begin
      tests_failed++;
      $display("FAIL busy_restart: busy=%b vec=%0d required 1 50", busy1, vec1);
    end
    wait_done(1, 2000, n);
    tests_run++;
    if (n < 0 || n + 100 !== 1024) begin
      tests_failed++;
      $display("FAIL busy_done_time: edges=%0d required 1024", (n < 0) ? n : n + 100);
    end
    tests_run++;
    if (xc1 !== 10'd512 || yc1 !== 10'd512 || xyc1 !== 10'd512) begin
      tests_failed++;
      $display("FAIL busy_counts: x=%0d y=%0d xy=%0d required 512", xc1, yc1, xyc1);
    end
    // Restart from DONE clears the counts.
    pulse_start();
    tests_run++;
    if (done1 !== 1'b0 || busy1 !== 1'b1 || xc1 !== 10'd0 || vec1 !== 9'd0) begin
      tests_failed++;
      $display("FAIL done_restart: done=%b busy=%b x=%0d vec=%0d required 0 1 0 0",
               done1, busy1, xc1, vec1);
    end
  endtask

  task automatic test_abort();
    int exc, eyc, exyc;
    fill_tables(2);
    for (int v = 0; v < 512; v++) x_tab[v] = 1'b1;
    do_reset();
    pulse_start();
    for (int i = 0; i < 20; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_counts(10, exc, eyc, exyc);
    tests_run++;
    if (vec1 !== 9'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: vec=%0d busy=%b done=%b required 0 0 0", vec1, busy1, done1);
    end
    tests_run++;
    if (int'(xc1) !== exc || int'(yc1) !== eyc || int'(xyc1) !== exyc) begin
      tests_failed++;
      $display("FAIL abort_counts: x=%0d y=%0d xy=%0d required %0d %0d %0d",
               xc1, yc1, xyc1, exc, eyc, exyc);
    end
    // abort beats start in IDLE; counts stay frozen.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (busy1 !== 1'b0 || int'(xc1) !== exc) begin
      tests_failed++;
      $display("FAIL abort_prio: busy=%b x=%0d required 0 %0d", busy1, xc1, exc);
    end
    pulse_start();
    tests_run++;
    if (xc1 !== 10'd0 || yc1 !== 10'd0 || xyc1 !== 10'd0 || busy1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_fresh: x=%0d y=%0d xy=%0d busy=%b required 0 0 0 1",
               xc1, yc1, xyc1, busy1);
    end
    // Abort landing on a SAMPLE edge drops that sample.
    for (int i = 0; i < 19; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_counts(9, exc, eyc, exyc);
    tests_run++;
    if (int'(xc1) !== exc || int'(yc1) !== eyc || busy1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_sample: x=%0d y=%0d busy=%b required %0d %0d 0",
               xc1, yc1, busy1, exc, eyc);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    fill_tables(2);
    do_reset();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (vec2 === 9'd37) begin found = 1'b1; break; end
      tick();
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL mid_reach37: vec=%0d required 37 within budget", vec2);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({vec1, vec2, busy1, busy2, done1, done2, xc1, yc1, xyc1, xc2, yc2, xyc2} !== 82'd0) begin
      tests_failed++;
      $display("FAIL mid_async: vec2=%0d busy2=%b x2=%0d y2=%0d required all 0",
               vec2, busy2, xc2, yc2);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    tests_run++;
    if (vec2 !== 9'd0 || busy2 !== 1'b0 || xc2 !== 10'd0 || yc2 !== 10'd0) begin
      tests_failed++;
      $display("FAIL mid_no_resume: vec=%0d busy=%b x=%0d y=%0d required 0", vec2, busy2, xc2, yc2);
    end
  endtask

`ifdef SWEEP_SIGNATURE_EN
  task automatic test_signature();
    int n;
    logic [15:0] s;
    logic fb;
    fill_tables(2);
    do_reset();
    tests_run++;
    if (sig2 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL sig_reset: sig=%h required 0000", sig2);
    end
    pulse_start();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (sig2 !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sig_abort: sig=%h required ffff", sig2);
    end
    s = 16'hFFFF;
    for (int v = 0; v < 512; v++) begin
      fb = s[0] ^ x_tab[v];
      s  = (s >> 1) ^ (fb ? 16'hB400 : 16'h0000);
      s  = s ^ {y_tab[v], 15'b0};
    end
    pulse_start();
    wait_done(2, 3000, n);
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (n !== 1536 || sig2 !== s) begin
      tests_failed++;
      $display("FAIL sig_sweep: sig=%h edges=%0d required %h 1536", sig2, n, s);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ab_parity();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
`ifdef SWEEP_SIGNATURE_EN
    test_signature();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/circuito_sweep_driver.md
Name: circuito_sweep_driver

Overview:
- Upstream stimulus-and-capture stage for the 9-input combinational `circuito` block (inputs A..I, outputs X, Y).
- On `start`, drives all 512 input combinations in ascending order and waits a programmable settle time per vector.
- Samples X and Y for each vector and accumulates per-output ones-counts, so the truth table is exercised exhaustively in hardware rather than by a single static vector.

Parameters:
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; sampled only in IDLE or DONE.
- abort  in  1  synchronous cancel of a running sweep.
- vec  out  9  drive to circuito: vec[8]=A, vec[7]=B, ..., vec[0]=I.
- x_in  in  1  X output of circuito.
- y_in  in  1  Y output of circuito.
- busy  out  1  high while sweep in progress (WAIT or SAMPLE).
- done  out  1  high in DONE; held until next start.
- x_count  out  10  number of vectors sampled with X=1.
- y_count  out  10  number of vectors sampled with Y=1.
- xy_count  out  10  number of vectors sampled with X=1 and Y=1.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (`rst_n`). All outputs are registered.
- Reset values: vec=0, busy=0, done=0, all counts=0, state=IDLE, settle counter=0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE/DONE + start=1 + abort=0:
  - next cycle vec=0, counts=0, done=0, state=WAIT.
  - settle counter loads SETTLE-1.
- WAIT: if settle counter==0, go to SAMPLE; otherwise decrement. WAIT lasts exactly SETTLE cycles.
- SAMPLE (one cycle): at its closing edge, x_in/y_in are sampled into the counts (+1 each where applicable).
  - If vec==511: state=DONE, vec holds 511.
  - Otherwise: vec=vec+1, reload settle counter, state=WAIT.
- Timing: per-vector period is SETTLE+1 cycles. done rises exactly 512*(SETTLE+1) cycles after the start edge.
- vec changes only on the edge leaving SAMPLE or on start; it is stable throughout WAIT and SAMPLE.
- Count width: maximum count is 512, which fits in 10 bits, so there is no overflow or wrap.
- busy equals (state==WAIT or state==SAMPLE).
- start while busy: ignored.
- start in DONE: restarts the sweep (counts cleared).
- abort=1 in WAIT or SAMPLE:
  - next state IDLE, vec=0, done=0.
  - counts frozen at the partial values; the sample at that edge is not accumulated.
- abort has priority over start. abort in IDLE/DONE has no effect, and start is ignored that cycle.
- rst_n low mid-sweep: immediate return to reset values. No resume.

Optional Feature:
- Macro: SWEEP_SIGNATURE_EN.
- When defined, adds port `signature  out  16`, a multiple-input signature register over the sweep:
  - Reset value 0x0000; loaded with 0xFFFF on an accepted start.
  - At each SAMPLE edge: fb = sig[0] ^ x_in; t = (sig >> 1) ^ (fb ? 0xB400 : 0); sig = t ^ {y_in, 15'b0}.
  - Frozen on abort and in DONE.
- When not defined: no signature port, no signature logic. All other behaviour is identical.

Test Plan:
- Reset then idle, start=0 -> vec=0, busy=0, done=0, counts=0 indefinitely.
- SETTLE=2, x_in=vec[8]&vec[7] (A&B), y_in=^vec (odd parity) -> done rises 1536 cycles after the start edge; x_count=128, y_count=256, xy_count=64; vec=511 held.
- SETTLE=1, x_in=y_in=1, pulse start again while busy at cycle 100 -> ignored. done at cycle 1024 with x_count=y_count=xy_count=512.
- Start, then abort after the 10th SAMPLE (x_in=1) -> IDLE next cycle, vec=0, done=0, x_count=10. A fresh start clears the counts to 0.
- rst_n low for 1 cycle mid-sweep at vec=37 -> all outputs return to reset values asynchronously. No activity until the next start.
- SWEEP_SIGNATURE_EN defined:
  - Start then abort in the first WAIT -> signature=0xFFFF.
  - Full sweep -> signature matches the bench reference model of the stated recurrence.
  - Macro undefined -> module elaborates without the signature port.
